instruction_fetch_unit: RTL and testbench

//  Initiator side of the external instruction-memory interface: drives mem_addr/mem_read_en,

---
 rtl/instruction_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Initiator side of the external instruction-memory interface. Walks a
//   fetch PC through memory, holding each address for MEM_LATENCY cycles
//   with mem_read_en high, then captures {pc, word} into a small prefetch
//   FIFO. The FIFO head is offered to decode with a valid/ready handshake.
//   A redirect from decode/branch logic flushes the FIFO and restarts the
//   fetch at a new word address. Memory is never written.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   mem_addr       out  word address to memory (always the fetch PC)
//   mem_read_en    out  read strobe, high while a read is in flight
//   mem_write_en   out  tied low
//   mem_write_val  out  tied low
//   mem_read_val   in   read data from memory
//   redirect_valid in   load redirect_pc as fetch PC and flush the FIFO
//   redirect_pc    in   new fetch word address
//   inst_valid     out  FIFO head holds an instruction
//   inst_ready     in   decode accepts the head this cycle
//   inst_data      out  head instruction word
//   inst_pc        out  head word address
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int MEM_WIDTH   = 32,
  parameter int MEM_SIZE    = 256,
  parameter int RESET_PC    = 212,
  parameter int MEM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  localparam int ADDR_W     = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  input  logic [MEM_WIDTH-1:0] mem_read_val,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [MEM_WIDTH-1:0] inst_data,
  output logic [ADDR_W-1:0]    inst_pc
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Keep the wait counter at least one bit wide even when MEM_LATENCY is 1.
  localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_RESET  = ADDR_W'(RESET_PC);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:0]     fetch_pc;
  logic [ADDR_W-1:0]     fetch_nxt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [WAIT_W-1:0]     wait_nxt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic                  push;
  logic                  pop;
  logic [MEM_WIDTH-1:0]  data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]     pc_q   [FIFO_DEPTH];

  // A redirect discards both the pending push and any pop in the same cycle.
  assign pop       = inst_valid & inst_ready & ~redirect_valid;
  assign push      = (state == S_READ) & (wait_cnt == WAIT_LAST) & ~redirect_valid;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  assign mem_addr      = fetch_pc;
  assign mem_read_en   = (state == S_READ);
  assign mem_write_en  = 1'b0;
  assign mem_write_val = {MEM_WIDTH{1'b0}};
  assign inst_valid    = (count != CNT_ZERO);
  assign inst_data     = data_q[rd_ptr];
  assign inst_pc       = pc_q[rd_ptr];

  // Fetch FSM next-state, wait counter and fetch PC update.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    fetch_nxt = fetch_pc;
    if (redirect_valid) begin
      state_nxt = S_READ;
      wait_nxt  = WAIT_ZERO;
      fetch_nxt = redirect_pc;
    end else begin
      case (state)
        S_IDLE: begin
          wait_nxt = WAIT_ZERO;
          if (count < DEPTH_C) begin
            state_nxt = S_READ;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_READ: begin
          if (push) begin
            wait_nxt = WAIT_ZERO;
            if (fetch_pc == LAST_ADDR) begin
              fetch_nxt = ADDR_ZERO;
            end else begin
              fetch_nxt = fetch_pc + ADDR_W'(1);
            end
            // Uses the post-edge count, so a pop this cycle keeps streaming.
            if (count_nxt < DEPTH_C) begin
              state_nxt = S_READ;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          wait_nxt  = WAIT_ZERO;
        end
      endcase
    end
  end

  // Fetch FSM state, wait counter and fetch PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= WAIT_ZERO;
      fetch_pc <= PC_RESET;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      fetch_pc <= fetch_nxt;
    end
  end

  // Prefetch FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= CNT_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= {MEM_WIDTH{1'b0}};
        pc_q[i]   <= ADDR_ZERO;
      end
    end else if (redirect_valid) begin
      // Flush: collapse the write pointer onto the untouched read pointer.
      wr_ptr <= rd_ptr;
      count  <= CNT_ZERO;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= mem_read_val;
        pc_q[wr_ptr]   <= fetch_pc;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  int          tests_run;
  int          tests_failed;

  // DUT A: MEM_LATENCY = 1
  logic        rst_a;
  logic [7:0]  addr_a;
  logic        rd_en_a;
  logic        wr_en_a;
  logic [31:0] wr_val_a;
  logic [31:0] rd_val_a;
  logic        redir_a;
  logic [7:0]  redir_pc_a;
  logic        valid_a;
  logic        ready_a;
  logic [31:0] data_a;
  logic [7:0]  pc_a;

  // DUT B: MEM_LATENCY = 3
  logic        rst_b;
  logic [7:0]  addr_b;
  logic        rd_en_b;
  logic        wr_en_b;
  logic [31:0] wr_val_b;
  logic [31:0] rd_val_b;
  logic        redir_b;
  logic [7:0]  redir_pc_b;
  logic        valid_b;
  logic        ready_b;
  logic [31:0] data_b;
  logic [7:0]  pc_b;

  // Memory image; every unlisted word reads as zero.
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    case (a)
      8'd212:  return 32'h0000_1825;
      8'd213:  return 32'h2402_0001;
      8'd214:  return 32'hAC62_0000;
      8'd215:  return 32'h0062_2021;
      8'd216:  return 32'h1440_FFFD;
      8'd236:  return 32'h0000_1025;
      8'd237:  return 32'h8C50_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign rd_val_a = mem_word(addr_a);
  assign rd_val_b = mem_word(addr_b);

  instruction_fetch_unit #(.MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(rst_a),
    .mem_addr(addr_a), .mem_read_en(rd_en_a), .mem_write_en(wr_en_a),
    .mem_write_val(wr_val_a), .mem_read_val(rd_val_a),
    .redirect_valid(redir_a), .redirect_pc(redir_pc_a),
    .inst_valid(valid_a), .inst_ready(ready_a),
    .inst_data(data_a), .inst_pc(pc_a)
  );

  instruction_fetch_unit #(.MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset(rst_b),
    .mem_addr(addr_b), .mem_read_en(rd_en_b), .mem_write_en(wr_en_b),
    .mem_write_val(wr_val_b), .mem_read_val(rd_val_b),
    .redirect_valid(redir_b), .redirect_pc(redir_pc_b),
    .inst_valid(valid_b), .inst_ready(ready_b),
    .inst_data(data_b), .inst_pc(pc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pre_reset;
    logic        redir;
    logic [7:0]  redir_pc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [7:0]  exp_pc;
    logic [7:0]  exp_addr;
    logic        exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic pr, input logic rv, input logic [7:0] rp,
                              input logic rdy, input logic ev, input logic [31:0] ed,
                              input logic [7:0] ep, input logic [7:0] ea, input logic er);
    vec_t v;
    v.pre_reset = pr; v.redir = rv; v.redir_pc = rp; v.ready = rdy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_pc = ep; v.exp_addr = ea; v.exp_rd = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Pulse reset on DUT A, checking the values held during reset.
  task automatic reset_a();
    rst_a = 1'b1;
    redir_a = 1'b0;
    #1;
    check("rstA.valid", {31'd0, valid_a}, 32'd0);
    check("rstA.rd_en", {31'd0, rd_en_a}, 32'd0);
    check("rstA.addr", {24'd0, addr_a}, 32'd212);
    check("rstA.data", data_a, 32'd0);
    check("rstA.pc", {24'd0, pc_a}, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_a = 1'b1; redir_a = 1'b0; redir_pc_a = 8'd0; ready_a = 1'b0;
    rst_b = 1'b1; redir_b = 1'b0; redir_pc_b = 8'd0; ready_b = 1'b0;
    @(posedge clk); #1;

    // Streaming with decode always ready.
    vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 32'h0, 8'd0, 8'd212, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h0000_1825, 8'd212, 8'd213, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h2402_0001, 8'd213, 8'd214, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'hAC62_0000, 8'd214, 8'd215, 1'b1));
    // Decode stalled: fill to four, stop reading, then drain in order.
    vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 32'h0, 8'd0, 8'd212, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_1825, 8'd212, 8'd213, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_1825, 8'd212, 8'd214, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_1825, 8'd212, 8'd215, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_1825, 8'd212, 8'd216, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_1825, 8'd212, 8'd216, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h2402_0001, 8'd213, 8'd216, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'hAC62_0000, 8'd214, 8'd216, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h0062_2021, 8'd215, 8'd217, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h1440_FFFD, 8'd216, 8'd218, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h0000_0000, 8'd217, 8'd219, 1'b1));
    // Redirect to 236 with three entries buffered and a pop offered.
    vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 32'h0, 8'd0, 8'd212, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_1825, 8'd212, 8'd213, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_1825, 8'd212, 8'd214, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 32'h0000_1825, 8'd212, 8'd215, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'd236, 1'b1, 1'b0, 32'h0, 8'd0, 8'd236, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h0000_1025, 8'd236, 8'd237, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h8C50_0000, 8'd237, 8'd238, 1'b1));
    // Redirect to 254: address wraps 255 -> 0.
    vecs.push_back(mk(1'b0, 1'b1, 8'd254, 1'b1, 1'b0, 32'h0, 8'd0, 8'd254, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h0, 8'd254, 8'd255, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h0, 8'd255, 8'd0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h0, 8'd0, 8'd1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 32'h0, 8'd1, 8'd2, 1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_reset) reset_a();
      redir_a    = vecs[i].redir;
      redir_pc_a = vecs[i].redir_pc;
      ready_a    = vecs[i].ready;
      @(posedge clk); #1;
      check($sformatf("v%0d.valid", i), {31'd0, valid_a}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d.addr", i), {24'd0, addr_a}, {24'd0, vecs[i].exp_addr});
      check($sformatf("v%0d.rd_en", i), {31'd0, rd_en_a}, {31'd0, vecs[i].exp_rd});
      check($sformatf("v%0d.wr_en", i), {31'd0, wr_en_a}, 32'd0);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d.data", i), data_a, vecs[i].exp_data);
        check($sformatf("v%0d.pc", i), {24'd0, pc_a}, {24'd0, vecs[i].exp_pc});
      end
    end
    redir_a = 1'b0;

    // Latency 3: each address held three cycles, one valid pulse per word.
    ready_b = 1'b1;
    rst_b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("lat3.k%0d.addr", k), {24'd0, addr_b}, 32'd212 + 32'((k - 1) / 3));
      check($sformatf("lat3.k%0d.rd_en", k), {31'd0, rd_en_b}, 32'd1);
      check($sformatf("lat3.k%0d.valid", k), {31'd0, valid_b},
            (k >= 4 && (k - 4) % 3 == 0) ? 32'd1 : 32'd0);
      if (k >= 4 && (k - 4) % 3 == 0) begin
        check($sformatf("lat3.k%0d.pc", k), {24'd0, pc_b}, 32'd212 + 32'((k - 4) / 3));
        check($sformatf("lat3.k%0d.data", k), data_b, mem_word(8'd212 + 8'((k - 4) / 3)));
      end
    end

    // Asynchronous reset in the middle of a read with one entry buffered.
    ready_b = 1'b0;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid.valid", {31'd0, valid_b}, 32'd1);
    check("mid.pc", {24'd0, pc_b}, 32'd212);
    check("mid.addr", {24'd0, addr_b}, 32'd213);
    check("mid.rd_en", {31'd0, rd_en_b}, 32'd1);
    #2;
    rst_b = 1'b1;
    #1;
    check("async.valid", {31'd0, valid_b}, 32'd0);
    check("async.rd_en", {31'd0, rd_en_b}, 32'd0);
    check("async.addr", {24'd0, addr_b}, 32'd212);
    check("async.data", data_b, 32'd0);
    check("async.pc", {24'd0, pc_b}, 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    check("post.valid", {31'd0, valid_b}, 32'd0);
    check("post.addr", {24'd0, addr_b}, 32'd212);
    check("post.rd_en", {31'd0, rd_en_b}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
